nibble_add_sched: RTL and testbench
===================================

# nibble_add_sched

Sequencer and two-way arbiter that shares one external 4-bit ripple-carry adder (nibble adder with carry-in) between two requesters. It performs full-width additions nibble-serially, LSB nibble first, chaining the carry through a register. It returns each result on a valid/ready response channel tagged with the requester ID. It sits between the adder datapath and its two client blocks, so the adder is never instantiated twice.

## Interface
- NIBBLES, 4, operand width in nibbles; W = 4*NIBBLES; legal range 1..16
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has operands
- req0_a, req0_b  in  W  requester 0 operands, sampled only on handshake
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid, req1_a, req1_b, req1_ready  same for requester 1
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_id  out  1  requester that issued the result
- resp_sum  out  W  (a + b) mod 2^W
- resp_carry  out  1  carry out of bit W-1
- add_a, add_b  out  4  nibble operands to adder
- add_cin  out  1  carry-in to adder
- add_sum  in  4  adder sum (combinational from add_a/add_b/add_cin)
- add_cout  in  1  adder carry out

## Operation
- States: IDLE, RUN, DONE.
- IDLE arbitration (combinational from valids):
  - Only one valid: grant it.
  - Both valid: grant the requester not served last.
  - last_served resets to 1, so req0 wins the first tie.
- Ready: reqN_ready = (state==IDLE) && grant==N. Ready may depend on valid; valid must not depend on ready.
- Handshake (valid && ready):
  - Latch a, b, id.
  - idx <= 0, carry <= 0.
  - Go to RUN.
- RUN, each cycle:
  - Drive add_a = a_q[4*idx+:4], add_b = b_q[4*idx+:4], add_cin = carry.
  - On the clock edge: sum_q[4*idx+:4] <= add_sum, carry <= add_cout, idx <= idx+1.
  - After the cycle with idx == NIBBLES-1, go to DONE.
- Outside RUN: add_a = add_b = 0, add_cin = 0.
- DONE:
  - resp_valid = 1; resp_sum = sum_q, resp_carry = carry, resp_id = id_q.
  - Outputs held stable while resp_ready = 0.
  - On resp_valid && resp_ready: last_served <= id_q, go to IDLE.
- Requests arriving during RUN/DONE wait; requesters hold valid and operands until ready.
- Overflow wraps modulo 2^W; the carry is reported only via resp_carry.
- idx width = clog2(NIBBLES), minimum 1 bit; idx is not used after the last nibble.

## Timing
- Reset state:
  - state = IDLE, idx = 0, carry = 0, sum_q = 0, id_q = 0, last_served = 1.
  - resp_valid = 0, req0_ready = req1_ready = 0 (req valids ignored during rst).
  - add_a = add_b = 0, add_cin = 0.
- Reset mid-RUN or mid-DONE: the operation is aborted and no response is produced. The next cycle is IDLE with reset values.
- Accept at edge T. RUN occupies cycles T+1 .. T+NIBBLES. resp_valid rises in cycle T+NIBBLES+1.
- Minimum spacing between accepts is NIBBLES+2 cycles with resp_ready tied high. The response handshake cycle is DONE; the next cycle is IDLE and can accept.
- No accept in the same cycle as a response handshake.
- The adder path is combinational within one cycle: add_* out -> add_sum/add_cout in -> registers.

## Test plan
- Single request, NIBBLES=4: req0 a=0x0B0B, b=0x0808, resp_ready=1 -> resp_valid exactly 5 cycles after accept, sum=0x1313, carry=0, id=0.
- Full carry ripple: req1 a=0xFFFF, b=0x0001 -> sum=0x0000, carry=1, id=1. add_cin observed as 0,1,1,1 across the four RUN cycles.
- Contention: req0 and req1 held valid continuously with distinct operands -> grants alternate 0,1,0,1. Never two readies in one cycle. Every result is tagged with the correct id.
- Backpressure: resp_ready=0 for 10 cycles in DONE -> resp_valid, sum, carry and id remain stable. No ready is asserted. After resp_ready=1, IDLE follows and the next accept occurs one cycle later.
- Reset mid-RUN: assert rst in the 2nd RUN cycle of a=0x1234, b=0x1111 -> no resp_valid. All outputs match reset values the next cycle. A subsequent request (0x0001+0x0001) returns 0x0002.
- NIBBLES=1 build: a=0xB, b=0x8 -> sum=0x3, carry=1, latency 2 cycles after accept.

Source files
------------

// File: rtl/nibble_add_sched.sv
// Shares one external 4-bit adder between two requesters; adds W-bit operands nibble-serially, LSB first.
// Response is valid NIBBLES+1 cycles after accept and is held in DONE while i_resp_ready is low.
module nibble_add_sched #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req0_valid,
    input  logic [W-1:0] i_req0_a,
    input  logic [W-1:0] i_req0_b,
    output logic         o_req0_ready,
    input  logic         i_req1_valid,
    input  logic [W-1:0] i_req1_a,
    input  logic [W-1:0] i_req1_b,
    output logic         o_req1_ready,
    output logic         o_resp_valid,
    input  logic         i_resp_ready,
    output logic         o_resp_id,
    output logic [W-1:0] o_resp_sum,
    output logic         o_resp_carry,
    output logic [3:0]   o_add_a,
    output logic [3:0]   o_add_b,
    output logic         o_add_cin,
    input  logic [3:0]   i_add_sum,
    input  logic         i_add_cout
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  r_state;
    logic [IW-1:0]           r_idx;
    logic                    r_carry;
    logic                    r_id;
    logic                    r_last;
    logic [NIBBLES-1:0][3:0] r_a;
    logic [NIBBLES-1:0][3:0] r_b;
    logic [NIBBLES-1:0][3:0] r_sum;

    logic w_grant;
    logic w_any;
    logic w_accept;
    logic w_last_nib;

    // On a tie, serve whichever requester was not served last.
    assign w_any      = i_req0_valid | i_req1_valid;
    assign w_grant    = (i_req0_valid & i_req1_valid) ? ~r_last : i_req1_valid;
    assign o_req0_ready = (r_state == IDLE) & ~i_rst & w_any & ~w_grant;
    assign o_req1_ready = (r_state == IDLE) & ~i_rst & w_grant;
    assign w_accept   = o_req0_ready | o_req1_ready;
    assign w_last_nib = (r_idx == IW'(NIBBLES - 1));

    assign o_add_a   = (r_state == RUN) ? r_a[r_idx] : 4'd0;
    assign o_add_b   = (r_state == RUN) ? r_b[r_idx] : 4'd0;
    assign o_add_cin = (r_state == RUN) ? r_carry : 1'b0;

    assign o_resp_valid = (r_state == DONE);
    assign o_resp_sum   = r_sum;
    assign o_resp_carry = r_carry;
    assign o_resp_id    = r_id;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_grant ? i_req1_a : i_req0_a;
                        r_b     <= w_grant ? i_req1_b : i_req0_b;
                        r_id    <= w_grant;
                        r_idx   <= '0;
                        r_carry <= 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // Carry chains through r_carry into the next nibble's add.
                    r_sum[r_idx] <= i_add_sum;
                    r_carry      <= i_add_cout;
                    r_idx        <= r_idx + 1'b1;
                    if (w_last_nib) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (i_resp_ready) begin
                        r_last  <= r_id;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_add_sched.sv
// Bench for nibble_add_sched: directed latency/carry/backpressure/reset cases plus random contention,
// checked against a scoreboard computing (a+b) and a last-served arbitration model.
module tb_nibble_add_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v0, v1, r0, r1, resp_v, resp_r, resp_id, resp_c;
    logic [15:0] a0, b0, a1, b1, resp_s;
    logic [3:0]  add_a, add_b, add_s;
    logic        cin, cout;

    logic        n_v0, n_v1, n_r0, n_r1, n_resp_v, n_resp_r, n_id, n_c, n_cin, n_cout;
    logic [3:0]  n_a0, n_b0, n_a1, n_b1, n_sum, n_add_a, n_add_b, n_add_s;

    // External adders the scheduler time-shares.
    assign {cout, add_s}     = {1'b0, add_a} + {1'b0, add_b} + {4'b0, cin};
    assign {n_cout, n_add_s} = {1'b0, n_add_a} + {1'b0, n_add_b} + {4'b0, n_cin};

    nibble_add_sched #(.NIBBLES(4)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .i_req0_a(a0), .i_req0_b(b0), .o_req0_ready(r0),
        .i_req1_valid(v1), .i_req1_a(a1), .i_req1_b(b1), .o_req1_ready(r1),
        .o_resp_valid(resp_v), .i_resp_ready(resp_r), .o_resp_id(resp_id),
        .o_resp_sum(resp_s), .o_resp_carry(resp_c),
        .o_add_a(add_a), .o_add_b(add_b), .o_add_cin(cin),
        .i_add_sum(add_s), .i_add_cout(cout)
    );

    nibble_add_sched #(.NIBBLES(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(n_v0), .i_req0_a(n_a0), .i_req0_b(n_b0), .o_req0_ready(n_r0),
        .i_req1_valid(n_v1), .i_req1_a(n_a1), .i_req1_b(n_b1), .o_req1_ready(n_r1),
        .o_resp_valid(n_resp_v), .i_resp_ready(n_resp_r), .o_resp_id(n_id),
        .o_resp_sum(n_sum), .o_resp_carry(n_c),
        .o_add_a(n_add_a), .o_add_b(n_add_b), .o_add_cin(n_cin),
        .i_add_sum(n_add_s), .i_add_cout(n_cout)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_resp  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
    } txn_t;

    txn_t sb[$];
    logic last_m = 1'b1;

    // Scoreboard and arbitration model for the 4-nibble instance.
    initial begin
        logic        exp_g;
        txn_t        t;
        logic [16:0] s17;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                last_m = 1'b1;
            end else begin
                if (r0 || r1) begin
                    check("one_ready", 32'(r0 & r1), 32'd0);
                    exp_g = (v0 && v1) ? ~last_m : v1;
                    check("grant", 32'(r1), 32'(exp_g));
                end
                if (v0 && r0) sb.push_back({1'b0, a0, b0});
                if (v1 && r1) sb.push_back({1'b1, a1, b1});
                if (resp_v && resp_r) begin
                    if (sb.size() == 0) begin
                        check("unexpected_resp", 32'(resp_v), 32'd0);
                    end else begin
                        t   = sb.pop_front();
                        s17 = {1'b0, t.a} + {1'b0, t.b};
                        check("resp_id", 32'(resp_id), 32'(t.id));
                        check("resp_sum", 32'(resp_s), 32'(s17[15:0]));
                        check("resp_carry", 32'(resp_c), 32'(s17[16]));
                        last_m = t.id;
                        n_resp++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input logic id);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (id ? r1 : r0) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_seen", 32'(ok), 32'd1);
    endtask

    // Issue one request from the posedge+1 phase; returns at the negedge of the first resp_valid cycle.
    task automatic do_req(input logic id, input logic [15:0] a, input logic [15:0] b,
                          output int lat, output logic [3:0] cins);
        cins = 4'h0;
        if (id) begin v1 = 1'b1; a1 = a; b1 = b; end
        else    begin v0 = 1'b1; a0 = a; b0 = b; end
        wait_ready(id);
        @(posedge clk); #1;
        if (id) v1 = 1'b0; else v0 = 1'b0;
        lat = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_v) break;
            if (lat <= 4) cins[2'(lat - 1)] = cin;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic traffic(input int n_want, input logic contend);
        int   target;
        logic acc0, acc1;
        target = n_resp + n_want;
        a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
        v0 = 1'b1; v1 = 1'b1;
        for (int cyc = 0; cyc < 2000 && n_resp < target; cyc++) begin
            @(negedge clk); #1;
            acc0 = v0 && r0;
            acc1 = v1 && r1;
            @(posedge clk); #1;
            if (acc0) begin
                a0 = 16'($urandom); b0 = 16'($urandom);
                v0 = contend || ($urandom_range(0, 1) == 1);
            end else if (!v0) begin
                v0 = ($urandom_range(0, 2) == 0);
            end
            if (acc1) begin
                a1 = 16'($urandom); b1 = 16'($urandom);
                v1 = contend || ($urandom_range(0, 1) == 1);
            end else if (!v1) begin
                v1 = ($urandom_range(0, 2) == 0);
            end
            if (!contend) resp_r = ($urandom_range(0, 3) != 0);
        end
        check("traffic_progress", 32'(n_resp >= target), 32'd1);
        v0 = 1'b0; v1 = 1'b0; resp_r = 1'b1;
        for (int i = 0; i < 100 && (sb.size() != 0 || resp_v); i++) @(posedge clk);
        #1;
    endtask

    initial begin
        int          lat;
        logic [3:0]  cins;
        logic [15:0] s_hold;
        logic        c_hold, id_hold, stable, seen;

        rst = 1'b1; resp_r = 1'b1;
        v0 = 1'b1; v1 = 1'b1; a0 = 16'h1111; b0 = 16'h2222; a1 = 16'h3333; b1 = 16'h4444;
        n_v0 = 1'b1; n_v1 = 1'b0; n_a0 = 4'h0; n_b0 = 4'h0; n_a1 = 4'h0; n_b1 = 4'h0; n_resp_r = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready0", 32'(r0), 32'd0);
        check("rst_ready1", 32'(r1), 32'd0);
        check("rst_resp_valid", 32'(resp_v), 32'd0);
        check("rst_add", 32'({add_a, add_b, cin}), 32'd0);
        check("rst_resp_regs", 32'({resp_s, resp_id, resp_c}), 32'd0);
        check("rst_n1_ready", 32'(n_r0), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0; n_v0 = 1'b0;

        // Single request and full carry ripple.
        do_req(1'b0, 16'h0B0B, 16'h0808, lat, cins);
        check("single_latency", 32'(lat), 32'd5);
        check("single_sum", 32'(resp_s), 32'h1313);
        check("single_carry", 32'(resp_c), 32'd0);
        check("single_id", 32'(resp_id), 32'd0);
        @(posedge clk); #1;
        do_req(1'b1, 16'hFFFF, 16'h0001, lat, cins);
        check("ripple_latency", 32'(lat), 32'd5);
        check("ripple_sum", 32'(resp_s), 32'h0000);
        check("ripple_carry", 32'(resp_c), 32'd1);
        check("ripple_id", 32'(resp_id), 32'd1);
        check("ripple_cin_seq", 32'(cins), 32'hE);
        @(posedge clk); #1;

        // Backpressure: response held for 10+ cycles, req1 waits.
        resp_r = 1'b0;
        do_req(1'b0, 16'hA5C3, 16'h7E19, lat, cins);
        check("bp_latency", 32'(lat), 32'd5);
        s_hold = resp_s; c_hold = resp_c; id_hold = resp_id;
        @(posedge clk); #1;
        v1 = 1'b1; a1 = 16'h0F0F; b1 = 16'h00F1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_v !== 1'b1 || resp_s !== s_hold || resp_c !== c_hold || resp_id !== id_hold || r0 || r1)
                stable = 1'b0;
            @(posedge clk); #1;
        end
        check("bp_stable", 32'(stable), 32'd1);
        resp_r = 1'b1;
        @(negedge clk);
        check("bp_hs_no_ready", 32'(r1), 32'd0);
        check("bp_hs_valid", 32'(resp_v), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_next_accept", 32'(r1), 32'd1);
        @(posedge clk); #1;
        v1 = 1'b0;
        for (int i = 0; i < 40 && (sb.size() != 0 || resp_v); i++) @(posedge clk);
        #1;

        // Reset during the second RUN cycle aborts the operation.
        v0 = 1'b1; a0 = 16'h1234; b0 = 16'h1111;
        wait_ready(1'b0);
        @(posedge clk); #1;
        v0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rrst_resp_valid", 32'(resp_v), 32'd0);
        check("rrst_add", 32'({add_a, add_b, cin}), 32'd0);
        check("rrst_resp_regs", 32'({resp_s, resp_id, resp_c}), 32'd0);
        check("rrst_ready", 32'({r0, r1}), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | resp_v;
        end
        check("rrst_no_resp", 32'(seen), 32'd0);
        @(posedge clk); #1;
        do_req(1'b0, 16'h0001, 16'h0001, lat, cins);
        check("rrst_next_sum", 32'(resp_s), 32'h0002);
        @(posedge clk); #1;

        // Random traffic: continuous contention, then random valids and backpressure.
        traffic(8, 1'b1);
        traffic(16, 1'b0);

        // Single-nibble build.
        n_v0 = 1'b1; n_a0 = 4'hB; n_b0 = 4'h8;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (n_r0) begin seen = 1'b1; break; end
        end
        check("n1_accept", 32'(seen), 32'd1);
        @(posedge clk); #1;
        n_v0 = 1'b0;
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (n_resp_v) break;
            @(posedge clk); #1;
            lat++;
        end
        check("n1_latency", 32'(lat), 32'd2);
        check("n1_sum", 32'(n_sum), 32'h3);
        check("n1_carry", 32'(n_c), 32'd1);
        check("n1_id", 32'(n_id), 32'd0);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
